// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the cv32e40p instruction-fetch sequencer.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    BUSY        = 2'd1,
    BRANCH_WAIT = 2'd2
  } fetch_seq_state_e;

  localparam logic [31:0] FETCH_WORD_BYTES = 32'd4;

endpackage

// File: rtl/cv32e40p_fetch_fifo.sv
// Synchronous FIFO of {addr, data} fetch entries; flush wins over push and pop.
module cv32e40p_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;
  assign count   = count_q;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is not reset; rdata is masked while empty so stale entries never leak out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cv32e40p_fetch_sequencer.sv
// IF-stage fetch sequencer: credit-limited OBI requests, response FIFO, branch redirect with flush.
module cv32e40p_fetch_sequencer
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o,
  output logic        perf_imiss_o
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_EXT = DEPTH[CNT_W:0];

  fetch_seq_state_e state_q;
  logic [31:0]      addr_q, target_q, raddr_q, branch_target;
  logic [CNT_W-1:0] cnt_q, flush_q, cnt_d, fifo_count;
  logic             hold_q, credit_ok, grant, rsp, drop, push, pop;
  logic             fifo_full, fifo_empty;
  logic             unused_addr_lsb;

  assign branch_target   = {branch_addr_i[31:2], 2'b00};
  assign unused_addr_lsb = ^branch_addr_i[1:0];

  assign credit_ok = ({1'b0, cnt_q} + {1'b0, fifo_count}) < DEPTH_EXT;

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    instr_req_o = 1'b0;
    unique case (state_q)
      BUSY:        instr_req_o = hold_q || (req_i && credit_ok && !branch_i);
      BRANCH_WAIT: instr_req_o = hold_q;
      default:     instr_req_o = 1'b0;
    endcase
  end

  assign instr_addr_o = addr_q;
  assign grant        = instr_req_o && instr_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp          = instr_rvalid_i && (cnt_q != '0);
  assign drop         = rsp && (flush_q != '0);
  assign push         = rsp && (flush_q == '0) && !branch_i;
  assign pop          = fetch_valid_o && fetch_ready_i;
  assign cnt_d        = cnt_q + CNT_W'(grant) - CNT_W'(rsp);

  assign fetch_valid_o = !fifo_empty;
  assign busy_o        = (cnt_q != '0) || instr_req_o;
  assign perf_imiss_o  = req_i && !fetch_valid_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      target_q <= '0;
      raddr_q  <= '0;
      cnt_q    <= '0;
      flush_q  <= '0;
      hold_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      flush_q <= flush_q - CNT_W'(drop);
      if (grant)            hold_q <= 1'b0;
      else if (instr_req_o) hold_q <= 1'b1;
      if (grant) addr_q  <= addr_q + FETCH_WORD_BYTES;
      if (push)  raddr_q <= raddr_q + FETCH_WORD_BYTES;

      unique case (state_q)
        IDLE: begin
          if (branch_i) begin
            state_q <= BUSY;
            addr_q  <= branch_target;
          end
        end
        BUSY: begin
          if (branch_i) begin
            // An ungranted request must stay stable, so park the target until it is granted.
            if (hold_q && !grant) begin
              target_q <= branch_target;
              state_q  <= BRANCH_WAIT;
            end else begin
              addr_q <= branch_target;
            end
          end else if (!req_i && !hold_q && (cnt_q == '0)) begin
            state_q <= IDLE;
          end
        end
        BRANCH_WAIT: begin
          if (grant) begin
            state_q <= BUSY;
            addr_q  <= branch_i ? branch_target : target_q;
            flush_q <= flush_q + CNT_W'(1) - CNT_W'(drop);
          end else if (branch_i) begin
            target_q <= branch_target;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Everything outstanding after this cycle belongs to the old stream.
      if (branch_i) begin
        flush_q <= cnt_d;
        raddr_q <= branch_target;
      end
    end
  end

  cv32e40p_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (branch_i),
    .push  (push),
    .wdata ({raddr_q, instr_rdata_i}),
    .pop   (pop),
    .rdata ({fetch_addr_o, fetch_rdata_o}),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The credit rule leaves no room for a push into a full FIFO unless the head is popped.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_cv32e40p_fetch_sequencer.sv
// Directed, cycle-scripted bench for cv32e40p_fetch_sequencer with DEPTH = 2.
module tb_cv32e40p_fetch_sequencer;
  import cv32e40p_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        fetch_valid_o;
  logic        fetch_ready_i = 1'b0;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        instr_req_o;
  logic        instr_gnt_i = 1'b0;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        busy_o;
  logic        perf_imiss_o;

  int tests_run = 0;
  int tests_failed = 0;

  cv32e40p_fetch_sequencer #(.DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_addr_o   (fetch_addr_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .busy_o         (busy_o),
    .perf_imiss_o   (perf_imiss_o)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic drive(input logic br, input logic [31:0] ba, input logic g,
                       input logic rv, input logic [31:0] rd);
    branch_i       = br;
    branch_addr_i  = ba;
    instr_gnt_i    = g;
    instr_rvalid_i = rv;
    instr_rdata_i  = rd;
    #1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_i = 1'b0; fetch_ready_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    next(); next();
    tests_run++;
    if ({instr_req_o, instr_addr_o, busy_o, perf_imiss_o} !== 35'h0) begin
      tests_failed++;
      $display("FAIL reset_obi: req=%b addr=%h busy=%b imiss=%b, want all 0", instr_req_o, instr_addr_o, busy_o, perf_imiss_o);
    end
    tests_run++;
    if ({fetch_valid_o, fetch_addr_o, fetch_rdata_o} !== 65'h0) begin
      tests_failed++;
      $display("FAIL reset_fetch: valid=%b addr=%h rdata=%h, want all 0", fetch_valid_o, fetch_addr_o, fetch_rdata_o);
    end
    rst_n = 1'b1; req_i = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tests_run++;
    if ({instr_req_o, perf_imiss_o} !== 2'b01) begin
      tests_failed++;
      $display("FAIL idle_req_alone: req=%b imiss=%b, want req=0 imiss=1", instr_req_o, perf_imiss_o);
    end
    next();
    tests_run++;
    if (instr_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_stays: req=%b, want 0", instr_req_o);
    end
  endtask

  task automatic test_boot();
    req_i = 1'b1; fetch_ready_i = 1'b1;
    drive(1'b1, 32'h0000_0083, 1'b1, 1'b0, '0);
    tests_run++;
    if (instr_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL boot_no_req_in_branch_cycle: req=%b, want 0", instr_req_o);
    end
    next();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tests_run++;
    if ({instr_req_o, instr_addr_o, busy_o} !== {1'b1, 32'h80, 1'b1}) begin
      tests_failed++;
      $display("FAIL boot_req_80: req=%b addr=%h busy=%b, want 1 00000080 1", instr_req_o, instr_addr_o, busy_o);
    end
    next();
    drive(1'b0, '0, 1'b1, 1'b1, 32'hA000_0080);
    tests_run++;
    if ({instr_req_o, instr_addr_o, fetch_valid_o} !== {1'b1, 32'h84, 1'b0}) begin
      tests_failed++;
      $display("FAIL boot_req_84: req=%b addr=%h valid=%b, want 1 00000084 0", instr_req_o, instr_addr_o, fetch_valid_o);
    end
    next();
    drive(1'b0, '0, 1'b1, 1'b1, 32'hA000_0084);
    tests_run++;
    if ({fetch_valid_o, fetch_addr_o, fetch_rdata_o} !== {1'b1, 32'h80, 32'hA000_0080}) begin
      tests_failed++;
      $display("FAIL boot_head_80: valid=%b addr=%h rdata=%h, want 1 00000080 a0000080", fetch_valid_o, fetch_addr_o, fetch_rdata_o);
    end
    tests_run++;
    if (instr_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL boot_credit_stall: req=%b, want 0", instr_req_o);
    end
    next();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tests_run++;
    if ({fetch_valid_o, fetch_addr_o, fetch_rdata_o, instr_req_o, instr_addr_o} !==
        {1'b1, 32'h84, 32'hA000_0084, 1'b1, 32'h88}) begin
      tests_failed++;
      $display("FAIL boot_head_84_req_88: valid=%b faddr=%h rdata=%h req=%b addr=%h", fetch_valid_o, fetch_addr_o, fetch_rdata_o, instr_req_o, instr_addr_o);
    end
    next();
    req_i = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b1, 32'hA000_0088);
    tests_run++;
    if ({fetch_valid_o, instr_req_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL boot_drain: valid=%b req=%b, want 0 0", fetch_valid_o, instr_req_o);
    end
    next();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tests_run++;
    if ({fetch_valid_o, fetch_addr_o, fetch_rdata_o, busy_o} !== {1'b1, 32'h88, 32'hA000_0088, 1'b0}) begin
      tests_failed++;
      $display("FAIL boot_head_88: valid=%b addr=%h rdata=%h busy=%b", fetch_valid_o, fetch_addr_o, fetch_rdata_o, busy_o);
    end
    next();
    req_i = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tests_run++;
    if ({fetch_valid_o, instr_req_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL boot_back_to_idle: valid=%b req=%b, want 0 0", fetch_valid_o, instr_req_o);
    end
  endtask

  task automatic test_back_pressure();
    req_i = 1'b1; fetch_ready_i = 1'b0;
    drive(1'b1, 32'h0000_1000, 1'b1, 1'b0, '0);
    next();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tests_run++;
    if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h1000}) begin
      tests_failed++;
      $display("FAIL bp_grant0: req=%b addr=%h, want 1 00001000", instr_req_o, instr_addr_o);
    end
    next();
    drive(1'b0, '0, 1'b1, 1'b1, 32'hB000_1000);
    tests_run++;
    if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h1004}) begin
      tests_failed++;
      $display("FAIL bp_grant1: req=%b addr=%h, want 1 00001004", instr_req_o, instr_addr_o);
    end
    next();
    drive(1'b0, '0, 1'b1, 1'b1, 32'hB000_1004);
    tests_run++;
    if (instr_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_stop_c3: req=%b, want 0", instr_req_o);
    end
    next();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tests_run++;
    if ({instr_req_o, fetch_valid_o, fetch_addr_o} !== {1'b0, 1'b1, 32'h1000}) begin
      tests_failed++;
      $display("FAIL bp_full_hold: req=%b valid=%b faddr=%h, want 0 1 00001000", instr_req_o, fetch_valid_o, fetch_addr_o);
    end
    next();
    fetch_ready_i = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tests_run++;
    if ({instr_req_o, busy_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL bp_stop_until_pop: req=%b busy=%b, want 0 0", instr_req_o, busy_o);
    end
    next();
    fetch_ready_i = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tests_run++;
    if ({instr_req_o, instr_addr_o, fetch_addr_o} !== {1'b1, 32'h1008, 32'h1004}) begin
      tests_failed++;
      $display("FAIL bp_one_after_pop: req=%b addr=%h faddr=%h, want 1 00001008 00001004", instr_req_o, instr_addr_o, fetch_addr_o);
    end
    next();
    drive(1'b0, '0, 1'b1, 1'b1, 32'hB000_1008);
    tests_run++;
    if (instr_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_only_one: req=%b, want 0", instr_req_o);
    end
    next();
    req_i = 1'b0; fetch_ready_i = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    next();
    tests_run++;
    if ({fetch_valid_o, fetch_addr_o, fetch_rdata_o} !== {1'b1, 32'h1008, 32'hB000_1008}) begin
      tests_failed++;
      $display("FAIL bp_head_1008: valid=%b addr=%h rdata=%h", fetch_valid_o, fetch_addr_o, fetch_rdata_o);
    end
    next();
  endtask

  task automatic test_flush_in_flight();
    req_i = 1'b1; fetch_ready_i = 1'b1;
    drive(1'b1, 32'h0000_0100, 1'b1, 1'b0, '0);
    next();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    next();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tests_run++;
    if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h104}) begin
      tests_failed++;
      $display("FAIL flush_req_104: req=%b addr=%h, want 1 00000104", instr_req_o, instr_addr_o);
    end
    next();
    drive(1'b1, 32'h0000_0200, 1'b1, 1'b0, '0);
    tests_run++;
    if (instr_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_branch_cycle: req=%b, want 0", instr_req_o);
    end
    next();
    drive(1'b0, '0, 1'b1, 1'b1, 32'hDEAD_0100);
    tests_run++;
    if ({dut.flush_q, instr_req_o} !== {2'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL flush_count: flush_q=%0d req=%b, want 2 0", dut.flush_q, instr_req_o);
    end
    next();
    drive(1'b0, '0, 1'b1, 1'b1, 32'hDEAD_0104);
    tests_run++;
    if ({fetch_valid_o, instr_req_o, instr_addr_o} !== {1'b0, 1'b1, 32'h200}) begin
      tests_failed++;
      $display("FAIL flush_drop0_req200: valid=%b req=%b addr=%h, want 0 1 00000200", fetch_valid_o, instr_req_o, instr_addr_o);
    end
    next();
    req_i = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b1, 32'hC000_0200);
    tests_run++;
    if (fetch_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_drop1: valid=%b, want 0", fetch_valid_o);
    end
    next();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tests_run++;
    if ({fetch_valid_o, fetch_addr_o, fetch_rdata_o} !== {1'b1, 32'h200, 32'hC000_0200}) begin
      tests_failed++;
      $display("FAIL flush_first_200: valid=%b addr=%h rdata=%h", fetch_valid_o, fetch_addr_o, fetch_rdata_o);
    end
    next();
  endtask

  task automatic test_branch_ungranted();
    req_i = 1'b1; fetch_ready_i = 1'b1;
    drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, '0);
    next();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    next();
    req_i = 1'b0;
    drive(1'b1, 32'h0000_0300, 1'b0, 1'b0, '0);
    tests_run++;
    if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h40}) begin
      tests_failed++;
      $display("FAIL ungr_hold_on_branch: req=%b addr=%h, want 1 00000040", instr_req_o, instr_addr_o);
    end
    next();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    tests_run++;
    if ({instr_req_o, instr_addr_o, dut.state_q} !== {1'b1, 32'h40, BRANCH_WAIT}) begin
      tests_failed++;
      $display("FAIL ungr_branch_wait: req=%b addr=%h state=%0d, want 1 00000040 2", instr_req_o, instr_addr_o, dut.state_q);
    end
    next();
    req_i = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    next();
    drive(1'b0, '0, 1'b1, 1'b1, 32'hDEAD_0040);
    tests_run++;
    if ({instr_req_o, instr_addr_o, dut.flush_q} !== {1'b1, 32'h300, 2'd1}) begin
      tests_failed++;
      $display("FAIL ungr_next_300: req=%b addr=%h flush_q=%0d, want 1 00000300 1", instr_req_o, instr_addr_o, dut.flush_q);
    end
    next();
    req_i = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b1, 32'hC000_0300);
    tests_run++;
    if ({fetch_valid_o, instr_req_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL ungr_drop_40: valid=%b req=%b, want 0 0", fetch_valid_o, instr_req_o);
    end
    next();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    tests_run++;
    if ({fetch_valid_o, fetch_addr_o, fetch_rdata_o} !== {1'b1, 32'h300, 32'hC000_0300}) begin
      tests_failed++;
      $display("FAIL ungr_head_300: valid=%b addr=%h rdata=%h", fetch_valid_o, fetch_addr_o, fetch_rdata_o);
    end
    next();
  endtask

  task automatic test_gnt_rsp_branch();
    req_i = 1'b1; fetch_ready_i = 1'b1;
    drive(1'b1, 32'h0000_0500, 1'b1, 1'b0, '0);
    next();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    next();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    next();
    drive(1'b1, 32'h0000_0600, 1'b1, 1'b1, 32'hDEAD_0500);
    tests_run++;
    if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h504}) begin
      tests_failed++;
      $display("FAIL sim_held_504: req=%b addr=%h, want 1 00000504", instr_req_o, instr_addr_o);
    end
    next();
    tests_run++;
    if ({dut.flush_q, dut.cnt_q, fetch_valid_o} !== {2'd1, 2'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL sim_counts: flush_q=%0d cnt_q=%0d valid=%b, want 1 1 0", dut.flush_q, dut.cnt_q, fetch_valid_o);
    end
    drive(1'b0, '0, 1'b1, 1'b1, 32'hDEAD_0504);
    tests_run++;
    if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h600}) begin
      tests_failed++;
      $display("FAIL sim_req_600: req=%b addr=%h, want 1 00000600", instr_req_o, instr_addr_o);
    end
    next();
    req_i = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b1, 32'hC000_0600);
    tests_run++;
    if (fetch_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL sim_no_stale: valid=%b, want 0", fetch_valid_o);
    end
    next();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    tests_run++;
    if ({fetch_valid_o, fetch_addr_o, fetch_rdata_o} !== {1'b1, 32'h600, 32'hC000_0600}) begin
      tests_failed++;
      $display("FAIL sim_head_600: valid=%b addr=%h rdata=%h", fetch_valid_o, fetch_addr_o, fetch_rdata_o);
    end
    next();
  endtask

  task automatic test_wrap();
    req_i = 1'b1; fetch_ready_i = 1'b1;
    drive(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, '0);
    next();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    tests_run++;
    if ({instr_req_o, instr_addr_o} !== {1'b1, 32'hFFFF_FFFC}) begin
      tests_failed++;
      $display("FAIL wrap_req_fffffffc: req=%b addr=%h", instr_req_o, instr_addr_o);
    end
    next();
    drive(1'b0, '0, 1'b1, 1'b1, 32'hE000_FFFC);
    tests_run++;
    if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL wrap_req_0: req=%b addr=%h, want 1 00000000", instr_req_o, instr_addr_o);
    end
    next();
    req_i = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b1, 32'hE000_0000);
    tests_run++;
    if ({fetch_valid_o, fetch_addr_o} !== {1'b1, 32'hFFFF_FFFC}) begin
      tests_failed++;
      $display("FAIL wrap_head_fffffffc: valid=%b addr=%h", fetch_valid_o, fetch_addr_o);
    end
    next();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    tests_run++;
    if ({fetch_valid_o, fetch_addr_o, fetch_rdata_o} !== {1'b1, 32'h0, 32'hE000_0000}) begin
      tests_failed++;
      $display("FAIL wrap_head_0: valid=%b addr=%h rdata=%h", fetch_valid_o, fetch_addr_o, fetch_rdata_o);
    end
    next();
    drive(1'b0, '0, 1'b0, 1'b1, 32'hBAD0_BAD0);
    next();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    tests_run++;
    if ({fetch_valid_o, dut.cnt_q, busy_o} !== {1'b0, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL stray_rvalid: valid=%b cnt_q=%0d busy=%b, want 0 0 0", fetch_valid_o, dut.cnt_q, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    req_i = 1'b1; fetch_ready_i = 1'b1;
    drive(1'b1, 32'h0000_0700, 1'b1, 1'b0, '0);
    next();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    next();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    next();
    tests_run++;
    if ({instr_req_o, instr_addr_o, busy_o, dut.cnt_q} !== {1'b0, 32'h0, 1'b0, 2'd0}) begin
      tests_failed++;
      $display("FAIL reset_mid: req=%b addr=%h busy=%b cnt_q=%0d, want all 0", instr_req_o, instr_addr_o, busy_o, dut.cnt_q);
    end
    rst_n = 1'b1;
    next();
    tests_run++;
    if (instr_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_idle: req=%b, want 0", instr_req_o);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_back_pressure();
    test_flush_in_flight();
    test_branch_ungranted();
    test_gnt_rsp_branch();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
